stage0: RTL

STAGE0 -- requirements
Module: stage0

---
 rtl/stage0_pkg.sv | 23 ++
 rtl/stage0_if.sv | 29 ++
 rtl/stage0_fetch_skid.sv | 38 +++
 rtl/stage0.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/stage0_pkg.sv
// Shared CPU pipeline package.
// Holds the instruction width, the bubble encoding and the fetch FSM state
// encoding used by the fetch stage, its bus interface and its skid buffer.
package stage0_pkg;

    localparam int INSTR_W = 32;

    typedef logic [INSTR_W-1:0] word_t;

    // addi x0,x0,0 -- the canonical RISC-V no-op used for pipeline bubbles
    localparam word_t NOP_INSTR = 32'h00000013;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Force an address onto a word boundary
    function automatic word_t align_word(input word_t addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage0_if.sv
// Instruction memory request/response bus.
//   imem_req  : fetch stage requests a word at imem_addr
//   imem_addr : word-aligned request address
//   imem_ack  : memory response valid; imem_data is valid in the same cycle
//   imem_data : fetched instruction word
// master = fetch stage, slave = instruction memory.
interface stage0_if;
    import stage0_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack;
    word_t imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/stage0_fetch_skid.sv
// fetch_skid: one-entry buffer that parks a fetched word (and its PC) while
// the downstream stage is stalled.
//   clk, rst   : clock and synchronous active-high reset
//   load       : capture load_pc/load_instr
//   unload     : entry has been consumed by the outputs
//   clear      : flush the entry (redirect)
//   pc, instr  : buffered PC and instruction word
module fetch_skid
    import stage0_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  unload,
    input  logic  clear,
    input  word_t load_pc,
    input  word_t load_instr,
    output word_t pc,
    output word_t instr
);

    word_t pc_reg;
    word_t instr_reg;

    always_ff @(posedge clk) begin
        if (rst || clear || unload) begin
            pc_reg    <= '0;
            instr_reg <= '0;
        end else if (load) begin
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end
    end

    assign pc    = pc_reg;
    assign instr = instr_reg;

endmodule

// File: rtl/stage0.sv
// stage0: instruction fetch stage.
// Issues word fetches to instruction memory, registers the returned word for
// decode, inserts bubbles on missing data or redirects, and parks a word in a
// one-entry skid buffer when decode stalls.
//   clk, rst        : clock, synchronous active-high reset
//   en              : downstream advance enable (low = stall, outputs hold)
//   branch_taken    : one-cycle redirect request
//   branch_target   : redirect address (low two bits ignored)
//   imem            : instruction memory bus (master side)
//   PC_out          : address of instr_out
//   instr_out       : registered instruction word
//   valid_out       : instr_out is a real instruction (low = bubble)
module stage0
    import stage0_pkg::*;
#(
    parameter word_t RESET_VECTOR = 32'h00000000,
    parameter word_t NOP_INSTR    = stage0_pkg::NOP_INSTR
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     branch_taken,
    input  word_t    branch_target,
    stage0_if.master imem,
    output word_t    PC_out,
    output word_t    instr_out,
    output logic     valid_out
);

    logic [1:0] state_reg, state_next;
    word_t      fetch_pc_reg, fetch_pc_next;
    word_t      target_reg, target_next;
    word_t      pc_out_reg, pc_out_next;
    word_t      instr_reg, instr_next;
    logic       valid_reg, valid_next;

    logic       skid_load, skid_unload, skid_clear;
    word_t      skid_pc, skid_instr;
    word_t      branch_aligned;

    assign branch_aligned = align_word(branch_target);

    // HOLD already owns a word, so no request is outstanding there. DISCARD
    // keeps the old request up until memory answers it.
    assign imem.imem_req  = !rst && (state_reg != ST_HOLD);
    assign imem.imem_addr = fetch_pc_reg;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        target_next   = target_reg;
        pc_out_next   = pc_out_reg;
        instr_next    = instr_reg;
        valid_next    = valid_reg;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b0;

        if (branch_taken) begin
            // Redirect beats both stall and memory response: always a bubble.
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
            case (state_reg)
                ST_HOLD: begin
                    skid_clear    = 1'b1;
                    fetch_pc_next = branch_aligned;
                    state_next    = ST_FETCH;
                end
                ST_DISCARD: begin
                    // Newer redirect wins; if memory answers now, go straight on.
                    if (imem.imem_ack) begin
                        fetch_pc_next = branch_aligned;
                        state_next    = ST_FETCH;
                    end else begin
                        target_next = branch_aligned;
                    end
                end
                default: begin
                    if (imem.imem_ack) begin
                        fetch_pc_next = branch_aligned;
                    end else begin
                        // Request is in flight; it must complete before the
                        // address may change, so park the target.
                        target_next = branch_aligned;
                        state_next  = ST_DISCARD;
                    end
                end
            endcase
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (en) begin
                        pc_out_next   = skid_pc;
                        instr_next    = skid_instr;
                        valid_next    = 1'b1;
                        skid_unload   = 1'b1;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                        state_next    = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (en) begin
                        instr_next = NOP_INSTR;
                        valid_next = 1'b0;
                    end
                    if (imem.imem_ack) begin
                        fetch_pc_next = target_reg;
                        state_next    = ST_FETCH;
                    end
                end
                default: begin
                    if (imem.imem_ack) begin
                        if (en) begin
                            pc_out_next   = fetch_pc_reg;
                            instr_next    = imem.imem_data;
                            valid_next    = 1'b1;
                            fetch_pc_next = fetch_pc_reg + 32'd4;
                        end else begin
                            skid_load  = 1'b1;
                            state_next = ST_HOLD;
                        end
                    end else if (en) begin
                        instr_next = NOP_INSTR;
                        valid_next = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_FETCH;
            fetch_pc_reg <= RESET_VECTOR;
            target_reg   <= '0;
            pc_out_reg   <= '0;
            instr_reg    <= NOP_INSTR;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            target_reg   <= target_next;
            pc_out_reg   <= pc_out_next;
            instr_reg    <= instr_next;
            valid_reg    <= valid_next;
        end
    end

    fetch_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_pc    (fetch_pc_reg),
        .load_instr (imem.imem_data),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    assign PC_out    = pc_out_reg;
    assign instr_out = instr_reg;
    assign valid_out = valid_reg;

endmodule
